decode_cycle: RTL and testbench

DECODE_CYCLE -- requirements
Module: decode_cycle

---
 rtl/cpu_pkg.sv | 69 ++++++
 rtl/control_unit.sv | 57 +++++
 rtl/decode_cycle.sv | 126 ++++++++++++
 tb/tb_decode_cycle.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, ResultSrc and ALUControl encodings,
// and the decoded-control and ID/EX bundle layouts.
// No ports. Imported by control_unit and decode_cycle.
package cpu_pkg;

    // Opcode map, InstrD[32:28]. 0x0E..0x1F are undefined and decode as illegal.
    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_SLL  = 5'h06;
    localparam logic [4:0] OP_SRL  = 5'h07;
    localparam logic [4:0] OP_ADDI = 5'h08;
    localparam logic [4:0] OP_LDR  = 5'h09;
    localparam logic [4:0] OP_STR  = 5'h0A;
    localparam logic [4:0] OP_BEQ  = 5'h0B;
    localparam logic [4:0] OP_BNE  = 5'h0C;
    localparam logic [4:0] OP_JMP  = 5'h0D;

    // Writeback result mux select.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // ALU operation select.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6
    } alu_ctl_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        branch_ne;
        logic        jump;
        logic        alu_src;
        logic        illegal;
        result_src_e result_src;
        alu_ctl_e    alu_ctl;
    } ctrl_t;

    // Everything the ID/EX pipeline register carries.
    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [8:0]  pc;
        logic [8:0]  pc_plus4;
        ctrl_t       ctrl;
    } idex_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/control_unit.sv
// Opcode-to-control decoder.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: op_i (5-bit opcode) -> ctrl_o (decoded control bundle).
module control_unit
    import cpu_pkg::*;
(
    input  logic [4:0] op_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o            = '0;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.alu_ctl    = ALU_ADD;
        case (op_i)
            OP_NOP: ;
            OP_ADD: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctl = ALU_ADD; end
            OP_SUB: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctl = ALU_SUB; end
            OP_AND: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctl = ALU_AND; end
            OP_OR:  begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctl = ALU_OR;  end
            OP_XOR: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctl = ALU_XOR; end
            OP_SLL: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctl = ALU_SLL; end
            OP_SRL: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_ctl = ALU_SRL; end
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            OP_LDR: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OP_STR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            // Branches compare by subtraction in EX.
            OP_BEQ: begin
                ctrl_o.branch  = 1'b1;
                ctrl_o.alu_ctl = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.branch_ne = 1'b1;
                ctrl_o.alu_ctl   = ALU_SUB;
            end
            // JMP links: writes PC+1 to rd.
            OP_JMP: begin
                ctrl_o.jump       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_PC4;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: 16x32 register file, control decode, and the ID/EX register.
// Latency: 1 cycle InstrD -> E outputs. Backpressure: StallE holds ID/EX, FlushE bubbles it (flush wins).
// Ports: clk, rst (sync active-low); InstrD/PCD/PCPlus4D in; writeback RegWriteW/RDW/ResultW;
//        StallE/FlushE; E-stage operands, indices, PCs and control out.
// Build option: DECODE_BYPASS_EN makes a same-cycle writeback visible to the register read.
module decode_cycle
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] InstrD,
    input  logic [8:0]  PCD,
    input  logic [8:0]  PCPlus4D,
    input  logic        RegWriteW,
    input  logic [3:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        StallE,
    input  logic        FlushE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [3:0]  RS1E,
    output logic [3:0]  RS2E,
    output logic [3:0]  RDE,
    output logic [8:0]  PCE,
    output logic [8:0]  PCPlus4E,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        BranchNeE,
    output logic        JumpE,
    output logic        ALUSrcE,
    output logic        IllegalE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE
);

    logic [4:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic [15:0] imm16;

    assign op    = InstrD[32:28];
    assign rd    = InstrD[27:24];
    assign rs1   = InstrD[23:20];
    assign rs2   = InstrD[19:16];
    assign imm16 = InstrD[15:0];

    ctrl_t ctrl;

    control_unit u_control_unit (
        .op_i   (op),
        .ctrl_o (ctrl)
    );

    // Register file. Entry 0 is cleared on reset and never written; reads of
    // index 0 are forced to zero regardless.
    logic [31:0] regs_q [16];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (RegWriteW && (RDW != 4'd0)) begin
            regs_q[RDW] <= ResultW;
        end
    end

    logic [31:0] rd1_d, rd2_d;

    always_comb begin
        rd1_d = (rs1 == 4'd0) ? '0 : regs_q[rs1];
        rd2_d = (rs2 == 4'd0) ? '0 : regs_q[rs2];
`ifdef DECODE_BYPASS_EN
        // Write-through: a writeback landing this edge is seen by this read.
        if (RegWriteW && (rs1 != 4'd0) && (RDW == rs1)) rd1_d = ResultW;
        if (RegWriteW && (rs2 != 4'd0) && (RDW == rs2)) rd2_d = ResultW;
`endif
    end

    // ID/EX register.
    idex_t idex_d, idex_q;

    always_comb begin
        idex_d          = '0;
        idex_d.rd1      = rd1_d;
        idex_d.rd2      = rd2_d;
        idex_d.imm_ext  = sign_ext16(imm16);
        idex_d.rs1      = rs1;
        idex_d.rs2      = rs2;
        idex_d.rd       = rd;
        idex_d.pc       = PCD;
        idex_d.pc_plus4 = PCPlus4D;
        idex_d.ctrl     = ctrl;
    end

    // Priority: reset, then flush (bubble), then stall (hold).
    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else if (!StallE) begin
            idex_q <= idex_d;
        end
    end

    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm_ext;
    assign RS1E        = idex_q.rs1;
    assign RS2E        = idex_q.rs2;
    assign RDE         = idex_q.rd;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;
    assign RegWriteE   = idex_q.ctrl.reg_write;
    assign MemWriteE   = idex_q.ctrl.mem_write;
    assign BranchE     = idex_q.ctrl.branch;
    assign BranchNeE   = idex_q.ctrl.branch_ne;
    assign JumpE       = idex_q.ctrl.jump;
    assign ALUSrcE     = idex_q.ctrl.alu_src;
    assign IllegalE    = idex_q.ctrl.illegal;
    assign ResultSrcE  = idex_q.ctrl.result_src;
    assign ALUControlE = idex_q.ctrl.alu_ctl;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed opcode table plus hand-written
// reset, writeback/read, bypass, stall/flush and illegal/R0 sequences.
module tb_decode_cycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [32:0] InstrD;
    logic [8:0]  PCD, PCPlus4D;
    logic        RegWriteW;
    logic [3:0]  RDW;
    logic [31:0] ResultW;
    logic        StallE, FlushE;
    logic [31:0] RD1E, RD2E, ImmExtE;
    logic [3:0]  RS1E, RS2E, RDE;
    logic [8:0]  PCE, PCPlus4E;
    logic        RegWriteE, MemWriteE, BranchE, BranchNeE, JumpE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .StallE(StallE), .FlushE(FlushE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .BranchNeE(BranchNeE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
    );

    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  rs1, rs2, rd;
        logic [8:0]  pc, pc4;
        logic [6:0]  flags;   // {RegWrite, MemWrite, Branch, BranchNe, Jump, ALUSrc, Illegal}
        logic [1:0]  rsrc;
        logic [3:0]  alu;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic [31:0] imm_x;
        logic [6:0]  flags;
        logic [1:0]  rsrc;
        logic [3:0]  alu;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;
    logic [31:0] model [16];
    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".RD1E"},     RD1E,           e.rd1);
        chk({tag, ".RD2E"},     RD2E,           e.rd2);
        chk({tag, ".ImmExtE"},  ImmExtE,        e.imm);
        chk({tag, ".RS1E"},     32'(RS1E),      32'(e.rs1));
        chk({tag, ".RS2E"},     32'(RS2E),      32'(e.rs2));
        chk({tag, ".RDE"},      32'(RDE),       32'(e.rd));
        chk({tag, ".PCE"},      32'(PCE),       32'(e.pc));
        chk({tag, ".PCPlus4E"}, 32'(PCPlus4E),  32'(e.pc4));
        chk({tag, ".ctrl"}, 32'({RegWriteE, MemWriteE, BranchE, BranchNeE, JumpE, ALUSrcE, IllegalE}),
            32'(e.flags));
        chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(e.rsrc));
        chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.alu));
    endtask

    function automatic vec_t mkv(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                 input logic [3:0] rs2, input logic [15:0] imm, input logic [31:0] immx,
                                 input logic [6:0] flags, input logic [1:0] rsrc, input logic [3:0] alu);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.imm_x = immx;
        v.flags = flags; v.rsrc = rsrc; v.alu = alu;
        return v;
    endfunction

    task automatic drive(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [15:0] imm);
        InstrD = {op, rd, rs1, rs2, imm};
    endtask

    task automatic wb(input logic en, input logic [3:0] rd, input logic [31:0] val);
        RegWriteW = en; RDW = rd; ResultW = val;
    endtask

    // One clock; the bench's register model follows the same edge.
    task automatic tick();
        logic       do_wr, do_rst;
        logic [3:0] a;
        logic [31:0] d;
        do_rst = !rst;
        do_wr  = RegWriteW && (RDW != 4'd0);
        a = RDW; d = ResultW;
        @(posedge clk);
        if (do_rst) begin
            for (int k = 0; k < 16; k++) model[k] = '0;
        end else if (do_wr) begin
            model[a] = d;
        end
        #1;
    endtask

    initial begin
        exp_t ez, e, held;
        ez = '{default: '0};
        for (int k = 0; k < 16; k++) model[k] = '0;

        //            op     rd  rs1 rs2  imm       imm_x          flags        rsrc   alu
        vecs[0]  = mkv(5'h00, 1,  1,  2, 16'h0000, 32'h0000_0000, 7'b0000000, 2'b00, 4'd0);
        vecs[1]  = mkv(5'h01, 2,  3,  4, 16'h0001, 32'h0000_0001, 7'b1000000, 2'b00, 4'd0);
        vecs[2]  = mkv(5'h02, 3,  5,  6, 16'h7FFF, 32'h0000_7FFF, 7'b1000000, 2'b00, 4'd1);
        vecs[3]  = mkv(5'h03, 4,  7,  8, 16'h8000, 32'hFFFF_8000, 7'b1000000, 2'b00, 4'd2);
        vecs[4]  = mkv(5'h04, 5,  9, 10, 16'h1234, 32'h0000_1234, 7'b1000000, 2'b00, 4'd3);
        vecs[5]  = mkv(5'h05, 6, 11, 12, 16'hABCD, 32'hFFFF_ABCD, 7'b1000000, 2'b00, 4'd4);
        vecs[6]  = mkv(5'h06, 7, 13, 14, 16'h0002, 32'h0000_0002, 7'b1000000, 2'b00, 4'd5);
        vecs[7]  = mkv(5'h07, 8, 15,  0, 16'h0003, 32'h0000_0003, 7'b1000000, 2'b00, 4'd6);
        vecs[8]  = mkv(5'h08, 9,  1,  0, 16'hFFFE, 32'hFFFF_FFFE, 7'b1000010, 2'b00, 4'd0);
        vecs[9]  = mkv(5'h09, 10, 2,  0, 16'h0010, 32'h0000_0010, 7'b1000010, 2'b01, 4'd0);
        vecs[10] = mkv(5'h0A, 0,  3,  4, 16'hFFF0, 32'hFFFF_FFF0, 7'b0100010, 2'b00, 4'd0);
        vecs[11] = mkv(5'h0B, 0,  5,  6, 16'h0020, 32'h0000_0020, 7'b0010000, 2'b00, 4'd1);
        vecs[12] = mkv(5'h0C, 0,  7,  8, 16'hFFFC, 32'hFFFF_FFFC, 7'b0011000, 2'b00, 4'd1);
        vecs[13] = mkv(5'h0D, 15, 0,  0, 16'h0040, 32'h0000_0040, 7'b1000100, 2'b10, 4'd0);
        vecs[14] = mkv(5'h0E, 1,  2,  3, 16'h0000, 32'h0000_0000, 7'b0000001, 2'b00, 4'd0);
        vecs[15] = mkv(5'h15, 4,  5,  6, 16'h8001, 32'hFFFF_8001, 7'b0000001, 2'b00, 4'd0);
        vecs[16] = mkv(5'h1F, 15, 15, 15, 16'hFFFF, 32'hFFFF_FFFF, 7'b0000001, 2'b00, 4'd0);

        // Reset overrides a pending writeback and a live instruction.
        rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        wb(1'b1, 4'd5, 32'hDEAD_BEEF);
        drive(5'h01, 4'd2, 4'd3, 4'd4, 16'h8001);
        PCD = 9'h055; PCPlus4D = 9'h056;
        tick();
        check_all("reset", ez);

        // Write R5, then read it back.
        rst = 1'b1;
        wb(1'b1, 4'd5, 32'hDEAD_BEEF);
        drive(5'h00, 4'd0, 4'd0, 4'd0, 16'h0000);
        tick();
        wb(1'b0, 4'd0, 32'h0);
        drive(5'h01, 4'd1, 4'd5, 4'd0, 16'h0000);
        tick();
        chk("r5_written", RD1E, 32'hDEAD_BEEF);

        // Reset asserted mid-stall with a writeback pending.
        StallE = 1'b1;
        rst = 1'b0;
        wb(1'b1, 4'd6, 32'h6666_6666);
        tick();
        check_all("reset_stall", ez);

        // First cycle after reset loads normally; R5 and R6 read 0.
        rst = 1'b1; StallE = 1'b0;
        wb(1'b0, 4'd0, 32'h0);
        drive(5'h02, 4'd9, 4'd5, 4'd6, 16'h0010);
        PCD = 9'h020; PCPlus4D = 9'h021;
        tick();
        e = ez; e.rs1 = 5; e.rs2 = 6; e.rd = 9; e.pc = 9'h020; e.pc4 = 9'h021;
        e.imm = 32'h10; e.flags = 7'b1000000; e.alu = 4'd1;
        check_all("after_reset", e);

        // Write R3 = 0xAA, then ADD r4, r3, r0.
        wb(1'b1, 4'd3, 32'h0000_00AA);
        drive(5'h00, 4'd0, 4'd0, 4'd0, 16'h0000);
        tick();
        wb(1'b0, 4'd0, 32'h0);
        drive(5'h01, 4'd4, 4'd3, 4'd0, 16'h0000);
        PCD = 9'h030; PCPlus4D = 9'h031;
        tick();
        e = ez; e.rd1 = 32'hAA; e.rs1 = 3; e.rd = 4; e.pc = 9'h030; e.pc4 = 9'h031;
        e.flags = 7'b1000000;
        check_all("wr_rd", e);

        // Same-cycle writeback of R7 while reading it.
        wb(1'b1, 4'd7, 32'h0000_1234);
        drive(5'h01, 4'd1, 4'd7, 4'd0, 16'h0000);
        tick();
`ifdef DECODE_BYPASS_EN
        chk("bypass_rd1", RD1E, 32'h0000_1234);
`else
        chk("bypass_rd1", RD1E, 32'h0000_0000);
`endif

        // R0 write is ignored even with a same-cycle read of index 0.
        wb(1'b1, 4'd0, 32'hFFFF_FFFF);
        drive(5'h01, 4'd2, 4'd0, 4'd7, 16'h0000);
        tick();
        chk("r0_same_cycle", RD1E, 32'h0);
        chk("r7_after_write", RD2E, 32'h0000_1234);
        wb(1'b0, 4'd0, 32'h0);
        drive(5'h01, 4'd2, 4'd0, 4'd0, 16'h0000);
        tick();
        chk("r0_after_write", RD1E, 32'h0);

        // Preload R1..R15 with distinct values.
        for (int i = 1; i < 16; i++) begin
            wb(1'b1, 4'(i), 32'h1000_0000 + 32'h0101_0101 * i);
            tick();
        end
        wb(1'b0, 4'd0, 32'h0);

        // Opcode table.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            PCD = 9'(i * 2 + 9'h100); PCPlus4D = 9'(i * 2 + 9'h101);
            tick();
            e.rd1 = model[vecs[i].rs1]; e.rd2 = model[vecs[i].rs2];
            e.imm = vecs[i].imm_x;
            e.rs1 = vecs[i].rs1; e.rs2 = vecs[i].rs2; e.rd = vecs[i].rd;
            e.pc = 9'(i * 2 + 9'h100); e.pc4 = 9'(i * 2 + 9'h101);
            e.flags = vecs[i].flags; e.rsrc = vecs[i].rsrc; e.alu = vecs[i].alu;
            check_all($sformatf("vec%0d", i), e);
        end

        // Stall: two cycles frozen even while inputs and R1 change.
        drive(5'h01, 4'd8, 4'd1, 4'd2, 16'h0007);
        PCD = 9'h1A0; PCPlus4D = 9'h1A1;
        tick();
        held.rd1 = model[1]; held.rd2 = model[2]; held.imm = 32'h7;
        held.rs1 = 1; held.rs2 = 2; held.rd = 8; held.pc = 9'h1A0; held.pc4 = 9'h1A1;
        held.flags = 7'b1000000; held.rsrc = 2'b00; held.alu = 4'd0;
        check_all("pre_stall", held);
        StallE = 1'b1;
        drive(5'h0A, 4'd3, 4'd4, 4'd5, 16'h8888);
        PCD = 9'h1B0; PCPlus4D = 9'h1B1;
        wb(1'b1, 4'd1, 32'hCAFE_F00D);
        tick();
        check_all("stall1", held);
        wb(1'b0, 4'd0, 32'h0);
        tick();
        check_all("stall2", held);

        // Flush beats stall.
        FlushE = 1'b1;
        tick();
        check_all("stall_flush", ez);

        // Flushed illegal opcode never raises IllegalE.
        StallE = 1'b0;
        drive(5'h1F, 4'd1, 4'd1, 4'd1, 16'h0000);
        tick();
        check_all("flush_illegal", ez);

        // Unflushed illegal bundle raises IllegalE for exactly one cycle.
        FlushE = 1'b0;
        tick();
        chk("illegal_set", 32'(IllegalE), 32'd1);
        chk("illegal_ctrl", 32'({RegWriteE, MemWriteE, BranchE, BranchNeE, JumpE, ALUSrcE,
                                 ResultSrcE, ALUControlE}), 32'd0);
        chk("illegal_rd1", RD1E, 32'hCAFE_F00D);
        drive(5'h00, 4'd0, 4'd0, 4'd0, 16'h0000);
        tick();
        chk("illegal_clear", 32'(IllegalE), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
